// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset stage sequencer.
// Holds the FSM state enum, default parameters and a counter-width helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 8;
  localparam int DEF_ACK_TIMEOUT = 1024;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-high reset to 0.
// Ports: clk, rst, d (async level in), q (clk-domain level out).
module reset_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_stage_sequencer.sv
// Releases NUM_STAGES reset domains in order, each gated by its READY ack.
// Ports: CLK, RESET, PLL_LOCK, SW_RST_REQ, STAGE_READY in;
// STAGE_RESET, SEQ_DONE, SEQ_FAULT, FAULT_STAGE out (all registered).
module reset_stage_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              PLL_LOCK,
  input  logic                              SW_RST_REQ,
  input  logic [NUM_STAGES-1:0]             STAGE_READY,
  output logic [NUM_STAGES-1:0]             STAGE_RESET,
  output logic                              SEQ_DONE,
  output logic                              SEQ_FAULT,
  output logic [width_of(NUM_STAGES)-1:0]   FAULT_STAGE
);

  localparam int IW = width_of(NUM_STAGES);
  localparam int HW = width_of(HOLD_CYCLES);
  localparam int GW = width_of(GAP_CYCLES);
  localparam int AW = width_of(ACK_TIMEOUT);

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  logic          lock_s;
  state_t        state;
  logic [IW-1:0] idx;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] ack_cnt;
  logic          ready_sel;
  logic          abort;

  reset_sync_2ff u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  assign ready_sel = STAGE_READY[idx];
  assign abort     = (state != ST_HOLD) && (!lock_s || SW_RST_REQ);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_HOLD;
      idx         <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      ack_cnt     <= '0;
      STAGE_RESET <= '1;
      SEQ_DONE    <= 1'b0;
      SEQ_FAULT   <= 1'b0;
      FAULT_STAGE <= '0;
    end else if (abort) begin
      state       <= ST_HOLD;
      idx         <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      ack_cnt     <= '0;
      STAGE_RESET <= '1;
      SEQ_DONE    <= 1'b0;
      SEQ_FAULT   <= 1'b0;
      FAULT_STAGE <= '0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          STAGE_RESET <= '1;
          if (!lock_s || SW_RST_REQ) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            idx      <= '0;
            state    <= ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          STAGE_RESET[idx] <= 1'b0;
          ack_cnt          <= '0;
          state            <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // READY beats a coincident timeout.
          if (ready_sel) begin
            if (idx == IDX_LAST) begin
              state <= ST_RUN;
            end else if (GAP_CYCLES == 0) begin
              idx   <= idx + IW'(1);
              state <= ST_RELEASE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end else if (ack_cnt == ACK_LAST) begin
            STAGE_RESET <= '1;
            SEQ_FAULT   <= 1'b1;
            FAULT_STAGE <= idx;
            state       <= ST_FAULT;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            idx     <= idx + IW'(1);
            state   <= ST_RELEASE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_RUN: begin
          SEQ_DONE <= 1'b1;
        end
        ST_FAULT: begin
          STAGE_RESET <= '1;
          SEQ_FAULT   <= 1'b1;
          FAULT_STAGE <= idx;
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Directed + randomized bench for reset_stage_sequencer.
// Expected timing comes from an arithmetic release-schedule model.
module tb_reset_stage_sequencer;

  localparam int NS     = 4;
  localparam int GAP    = 8;
  localparam int ACK_TO = 1024;
  localparam int BIG    = 1 << 30;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          PLL_LOCK = 1'b1;
  logic          SW_RST_REQ = 1'b0;
  logic [NS-1:0] STAGE_READY = '0;
  logic [NS-1:0] STAGE_RESET;
  logic          SEQ_DONE;
  logic          SEQ_FAULT;
  logic [1:0]    FAULT_STAGE;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int rel     = 0;
  int dly [NS];

  always #5 CLK = ~CLK;

  reset_stage_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PLL_LOCK    (PLL_LOCK),
    .SW_RST_REQ  (SW_RST_REQ),
    .STAGE_READY (STAGE_READY),
    .STAGE_RESET (STAGE_RESET),
    .SEQ_DONE    (SEQ_DONE),
    .SEQ_FAULT   (SEQ_FAULT),
    .FAULT_STAGE (FAULT_STAGE)
  );

  // A released stage implies every lower stage is released too.
  always @(negedge CLK) begin : mono
    logic bad;
    bad = 1'b0;
    for (int j = 1; j < NS; j++)
      if (STAGE_RESET[j] !== 1'b1)
        for (int i = 0; i < j; i++)
          if (STAGE_RESET[i] !== 1'b0) bad = 1'b1;
    n_total++;
    assert (!bad) n_pass++;
    else begin
      n_fail++;
      $error("FAIL monotonic: observed %b required zeros as low prefix",
             STAGE_RESET);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d",
             tag, obs, exp, rel);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    rel++;
  endtask

  task automatic check_idle(input string tag, input bit with_stage);
    check({tag, ".rst"}, 32'(STAGE_RESET), 32'hF);
    check({tag, ".done"}, 32'(SEQ_DONE), 0);
    check({tag, ".fault"}, 32'(SEQ_FAULT), 0);
    if (with_stage) check({tag, ".fstage"}, 32'(FAULT_STAGE), 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    SW_RST_REQ = 1'b0;
    STAGE_READY = '0;
    repeat (2) tick();
    check_idle("reset", 1'b1);
    RESET = 1'b0;
    rel = 0;
  endtask

  // Stage 0 falls at t0. Each stage k's READY rises dly[k] cycles after
  // its own release; the ack is taken one edge later, unless the wait
  // already spans ACK_TO cycles. The next stage falls GAP+1 later.
  task automatic run_seq(input int t0, input int lim);
    int f [NS];
    int done_t, fault_t, fst, acc, stop;
    logic [NS-1:0] rdy, exp_rst;
    bit faulted;
    done_t = -1;
    fault_t = -1;
    fst = 0;
    for (int k = 0; k < NS; k++) f[k] = -1;
    f[0] = t0;
    for (int k = 0; k < NS; k++) begin
      if (dly[k] > ACK_TO - 1) begin
        fault_t = f[k] + ACK_TO;
        fst = k;
        break;
      end
      acc = f[k] + 1 + dly[k];
      if (k == NS - 1) done_t = acc + 1;
      else f[k+1] = acc + GAP + 1;
    end
    stop = ((fault_t >= 0) ? fault_t : done_t) + 3;
    if (lim < stop) stop = lim;
    while (rel < stop) begin
      for (int k = 0; k < NS; k++)
        rdy[k] = (f[k] >= 0) && (rel >= f[k] + dly[k]);
      STAGE_READY = rdy;
      tick();
      faulted = (fault_t >= 0) && (rel >= fault_t);
      for (int k = 0; k < NS; k++)
        exp_rst[k] = faulted || !((f[k] >= 0) && (rel >= f[k]));
      check("stage_reset", 32'(STAGE_RESET), 32'(exp_rst));
      check("seq_done", 32'(SEQ_DONE),
            32'((done_t >= 0) && (rel >= done_t)));
      check("seq_fault", 32'(SEQ_FAULT), 32'(faulted));
      if (faulted) check("fault_stage", 32'(FAULT_STAGE), 32'(fst));
    end
  endtask

  task automatic sw_abort(output int t0);
    SW_RST_REQ = 1'b1;
    STAGE_READY = '0;
    tick();
    SW_RST_REQ = 1'b0;
    check_idle("sw_abort", 1'b0);
    t0 = rel + 17;
  endtask

  initial begin : main
    int t0;
    int n;
    int m;
    PLL_LOCK = 1'b1;
    do_reset();

    dly = '{0, 0, 0, 0};
    run_seq(19, BIG);
    sw_abort(t0);

    dly = '{0, 0, 500, 0};
    run_seq(t0, BIG);
    sw_abort(t0);

    dly = '{0, 5000, 0, 0};
    run_seq(t0, BIG);
    sw_abort(t0);

    dly = '{0, 0, 0, ACK_TO - 1};
    run_seq(t0, BIG);

    n = rel;
    PLL_LOCK = 1'b0;
    tick();
    PLL_LOCK = 1'b1;
    tick();
    check("lockdrop.pre_rst", 32'(STAGE_RESET), 0);
    check("lockdrop.pre_done", 32'(SEQ_DONE), 1);
    tick();
    check("lockdrop.rst", 32'(STAGE_RESET), 32'hF);
    check("lockdrop.done", 32'(SEQ_DONE), 0);
    dly = '{0, 0, 0, 0};
    run_seq(n + 20, BIG);
    sw_abort(t0);

    repeat (6) begin
      for (int k = 0; k < NS; k++)
        dly[k] = ($urandom_range(0, 9) == 0) ?
                 int'($urandom_range(1020, 1026)) :
                 int'($urandom_range(0, 30));
      run_seq(t0, BIG);
      sw_abort(t0);
    end

    do_reset();
    for (int p = 0; p < 13; p++) begin
      PLL_LOCK = (p % 2 == 1);
      repeat (10) begin
        tick();
        check("toggle.rst", 32'(STAGE_RESET), 32'hF);
      end
    end
    m = rel;
    PLL_LOCK = 1'b1;
    dly = '{0, 0, 0, 0};
    run_seq(m + 19, m + 19 + 5);
    #2;
    RESET = 1'b1;
    #1;
    check_idle("async_rst", 1'b1);
    repeat (2) tick();
    check_idle("async_rst.hold", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
